// File: rtl/sa_22_pkg.sv
// Shared constants for the (2,2) corner-router switch allocator: route codes,
// flit type codes and small index helpers used by the top and the per-output arbiter.
package sa_22_pkg;

  localparam logic [3:0] DIR_N = 4'b0001;
  localparam logic [3:0] DIR_W = 4'b0010;
  localparam logic [3:0] DIR_L = 4'b0100;

  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  // Lane i and output port i share an index: lane 1 enters from N, lane 3 from W, lane 5 from L.
  localparam int PORT_N = 0;
  localparam int PORT_W = 1;
  localparam int PORT_L = 2;
  localparam int NUM_PORTS = 3;

  // (base + off) mod 3 for base, off in 0..2.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  // One-hot output port vector for a route code; zero for any illegal code.
  function automatic logic [2:0] dir_decode(input logic [3:0] dir);
    case (dir)
      DIR_N:   return 3'b001;
      DIR_W:   return 3'b010;
      DIR_L:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sa_22_arb.sv
// One output port of the switch: round-robin arbiter over the three lanes, wormhole
// lock FSM (head locks, owner's tail unlocks) and the registered output slot.
module sa_22_arb
  import sa_22_pkg::*;
#(
  parameter int DATASIZE = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               i_req,
  input  logic [2:0][DATASIZE-1:0] i_data,
  input  logic                     i_ready,
  output logic [2:0]               o_grant,
  output logic [DATASIZE-1:0]      o_data,
  output logic                     o_valid,
  output logic                     o_dbg_state
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]          r_state;
  logic [1:0]          r_owner;
  logic [1:0]          r_ptr;
  logic                r_valid;
  logic [DATASIZE-1:0] r_data;

  logic       w_can;
  logic [2:0] w_elig;
  logic       w_fire;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic [1:0] w_type;

  // Free slot or one draining this cycle can take a new flit.
  assign w_can = !r_valid || i_ready;

  always_comb begin
    w_elig = '0;
    for (int k = 0; k < 3; k++) begin
      w_elig[k] = i_req[k] && ((r_state == ST_IDLE) || (r_owner == 2'(k)));
    end
  end

  always_comb begin
    w_fire = 1'b0;
    w_win  = r_ptr;
    w_idx  = r_ptr;
    for (int n = 0; n < 3; n++) begin
      w_idx = rr_idx(r_ptr, 2'(n));
      if (!w_fire && w_can && w_elig[w_idx]) begin
        w_fire = 1'b1;
        w_win  = w_idx;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (w_fire) o_grant[w_win] = 1'b1;
  end

  assign w_type = i_data[w_win][DATASIZE-1 -: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_data  <= i_data[w_win];
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Pointer only advances at packet starts so a locked packet does not skew fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd0;
    end else if (w_fire && ((w_type == FT_HEAD) || (w_type == FT_SINGLE))) begin
      r_ptr <= rr_idx(w_win, 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire && (w_type == FT_HEAD)) begin
            r_state <= ST_LOCKED;
            r_owner <= w_win;
          end
        end
        ST_LOCKED: begin
          // Only the owner can win while locked, so its tail releases the port.
          if (w_fire && (w_type == FT_TAIL)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_dbg_state = r_state[0];

endmodule

// File: rtl/sa_22.sv
// Switch allocator + crossbar for corner router (2,2): decodes RC lane routes, drops
// illegal/U-turn flits, arbitrates N/W/L outputs and reports N/W windowed pressure.
module sa_22
  import sa_22_pkg::*;
#(
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3
) (
  input  logic                sa_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in_1,
  input  logic [DATASIZE-1:0] data_in_3,
  input  logic [DATASIZE-1:0] data_in_5,
  input  logic [3:0]          direction_in_1,
  input  logic [3:0]          direction_in_3,
  input  logic [3:0]          direction_in_5,
  input  logic                valid_in_1,
  input  logic                valid_in_3,
  input  logic                valid_in_5,
  output logic                ready_out_1,
  output logic                ready_out_3,
  output logic                ready_out_5,
  output logic [DATASIZE-1:0] N_data_out,
  output logic [DATASIZE-1:0] W_data_out,
  output logic [DATASIZE-1:0] L_data_out,
  output logic                N_valid_out,
  output logic                W_valid_out,
  output logic                L_valid_out,
  input  logic                N_ready_in,
  input  logic                W_ready_in,
  input  logic                L_ready_in,
  output logic [WIDTH:0]      N_pressure_out,
  output logic [WIDTH:0]      W_pressure_out,
  output logic                err_route,
  output logic [2:0]          dbg_lock_state
);

  logic [2:0]                      w_valid;
  logic [2:0][3:0]                 w_dir;
  logic [2:0][DATASIZE-1:0]        w_data;
  logic [2:0][2:0]                 w_tgt;
  logic [2:0]                      w_uturn;
  logic [2:0]                      w_illegal;
  logic [2:0][2:0]                 w_req;
  logic [2:0][2:0]                 w_grant;
  logic [2:0][DATASIZE-1:0]        w_odata;
  logic [2:0]                      w_ovalid;
  logic [2:0]                      w_oready;
  logic [2:0]                      w_lock;
  logic [2:0]                      w_lane_ready;
  logic                            w_fire_n;
  logic                            w_fire_w;

  logic [2:0]       r_win;
  logic [WIDTH:0]   r_cnt_n;
  logic [WIDTH:0]   r_cnt_w;
  logic [WIDTH:0]   r_press_n;
  logic [WIDTH:0]   r_press_w;
  logic             r_err;

  // Lanes are masked during reset so nothing is reported consumed.
  assign w_valid  = {valid_in_5, valid_in_3, valid_in_1} & {3{rst_n}};
  assign w_dir    = {direction_in_5, direction_in_3, direction_in_1};
  assign w_data   = {data_in_5, data_in_3, data_in_1};
  assign w_oready = {L_ready_in, W_ready_in, N_ready_in};

  always_comb begin
    w_tgt     = '0;
    w_uturn   = '0;
    w_illegal = '0;
    w_req     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_tgt[i]     = dir_decode(w_dir[i]);
      w_uturn[i]   = ((i == PORT_N) && w_tgt[i][PORT_N]) || ((i == PORT_W) && w_tgt[i][PORT_W]);
      w_illegal[i] = w_valid[i] && ((w_tgt[i] == 3'b000) || w_uturn[i]);
      for (int o = 0; o < NUM_PORTS; o++) begin
        w_req[o][i] = w_valid[i] && w_tgt[i][o] && !w_uturn[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    sa_22_arb #(.DATASIZE(DATASIZE)) u_arb (
      .clk         (sa_clk),
      .rst_n       (rst_n),
      .i_req       (w_req[g]),
      .i_data      (w_data),
      .i_ready     (w_oready[g]),
      .o_grant     (w_grant[g]),
      .o_data      (w_odata[g]),
      .o_valid     (w_ovalid[g]),
      .o_dbg_state (w_lock[g])
    );
  end

  // Illegal flits are swallowed so they cannot block the lane.
  assign w_lane_ready = w_illegal | w_grant[PORT_N] | w_grant[PORT_W] | w_grant[PORT_L];
  assign w_fire_n     = |w_grant[PORT_N];
  assign w_fire_w     = |w_grant[PORT_W];

  function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH:0] v, input logic inc);
    return (inc && (v != {(WIDTH+1){1'b1}})) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge sa_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win     <= 3'd0;
      r_cnt_n   <= '0;
      r_cnt_w   <= '0;
      r_press_n <= '0;
      r_press_w <= '0;
    end else begin
      r_win <= r_win + 3'd1;
      if (r_win == 3'd7) begin
        r_press_n <= sat_inc(r_cnt_n, w_fire_n);
        r_press_w <= sat_inc(r_cnt_w, w_fire_w);
        r_cnt_n   <= '0;
        r_cnt_w   <= '0;
      end else begin
        r_cnt_n <= sat_inc(r_cnt_n, w_fire_n);
        r_cnt_w <= sat_inc(r_cnt_w, w_fire_w);
      end
    end
  end

  always_ff @(posedge sa_clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= |w_illegal;
  end

  assign ready_out_1    = w_lane_ready[PORT_N];
  assign ready_out_3    = w_lane_ready[PORT_W];
  assign ready_out_5    = w_lane_ready[PORT_L];
  assign N_data_out     = w_odata[PORT_N];
  assign W_data_out     = w_odata[PORT_W];
  assign L_data_out     = w_odata[PORT_L];
  assign N_valid_out    = w_ovalid[PORT_N];
  assign W_valid_out    = w_ovalid[PORT_W];
  assign L_valid_out    = w_ovalid[PORT_L];
  assign N_pressure_out = r_press_n;
  assign W_pressure_out = r_press_w;
  assign err_route      = r_err;
  assign dbg_lock_state = w_lock;

endmodule
